// File: rtl/alu_pipe.sv
// alu_pipe: handshaked, registered ALU with compare, shift and iterative multiply.
// Ports: clk/reset_n, in_valid/in_ready + src_a/src_b/sig_alu_control request side,
//        out_valid/out_ready + result/zero/bad_op response side.
module alu_pipe #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 6
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] src_a,
    input  logic [WIDTH-1:0] src_b,
    input  logic [4:0]       sig_alu_control,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             zero,
    output logic             bad_op
);

    localparam int SH_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        IDLE,
        MUL,
        DONE
    } state_t;

    state_t           state;
    logic [WIDTH-1:0] acc;
    logic [WIDTH-1:0] mcand;
    logic [WIDTH-1:0] mplier;
    logic [CNT_W-1:0] cnt;

    logic [WIDTH-1:0] alu_res;
    logic             alu_bad;
    logic [WIDTH-1:0] acc_nxt;
    logic             accept;
    logic             is_mul;
    logic             slt;

    assign in_ready = (state == IDLE) && (!out_valid || out_ready);
    assign accept   = in_valid && in_ready;
    assign is_mul   = (sig_alu_control == 5'd7);
    assign acc_nxt  = mplier[0] ? (acc + mcand) : acc;
    assign slt      = $signed(src_a) < $signed(src_b);

    // Single-cycle ops; MUL is handled by the shift-add sequencer below.
    always_comb begin
        alu_res = '0;
        alu_bad = 1'b0;
        unique case (sig_alu_control)
            5'd0:    alu_res = src_a & src_b;
            5'd1:    alu_res = src_a | src_b;
            5'd2:    alu_res = src_a + src_b;
            5'd3:    alu_res = src_a - src_b;
            5'd4:    alu_res = {{(WIDTH-1){1'b0}}, slt};
            5'd5:    alu_res = src_a << src_b[SH_W-1:0];
            5'd6:    alu_res = src_a >> src_b[SH_W-1:0];
            5'd7:    alu_res = '0;
            default: alu_bad = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            result    <= '0;
            zero      <= 1'b0;
            bad_op    <= 1'b0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        if (is_mul) begin
                            state     <= MUL;
                            acc       <= '0;
                            mcand     <= src_a;
                            mplier    <= src_b;
                            cnt       <= '0;
                            out_valid <= 1'b0;
                        end else begin
                            result    <= alu_res;
                            zero      <= (alu_res == '0);
                            bad_op    <= alu_bad;
                            out_valid <= 1'b1;
                        end
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                    end
                end
                MUL: begin
                    acc    <= acc_nxt;
                    mcand  <= mcand << 1;
                    mplier <= mplier >> 1;
                    cnt    <= cnt + CNT_W'(1);
                    // Last iteration: publish the accumulator including this step.
                    if (cnt == CNT_W'(WIDTH-1)) begin
                        state     <= DONE;
                        result    <= acc_nxt;
                        zero      <= (acc_nxt == '0);
                        bad_op    <= 1'b0;
                        out_valid <= 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
